// File: rtl/ofdm_cp_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_cp_serializer
//  Description : Takes one I frame and one Q frame (8 x 16-bit words each)
//                per OFDM symbol from the FFT and emits them as a serial I/Q
//                sample stream. The last CP_LEN samples are replayed first
//                as a cyclic prefix. Valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofdm_cp_serializer #(
    parameter int N_PT   = 8,   // samples per symbol; only 8 is supported
    parameter int W      = 16,  // sample width
    parameter int CP_LEN = 2    // cyclic prefix length, 0..7 (0 = no prefix)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PT*W-1:0]   in_phase,
    input  logic [N_PT*W-1:0]   in_quad,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [W-1:0]        out_i,
    output logic [W-1:0]        out_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sop,
    output logic                out_eop,
    output logic                out_is_cp
);

    // The index is 3 bits wide because the symbol length is fixed at 8.
    localparam logic [2:0] c_IDX_LAST = 3'(N_PT - 1);
    // Prefix replays the tail of the symbol, so it starts at N_PT-CP_LEN.
    localparam logic [2:0] c_CP_START = 3'(N_PT - CP_LEN);
    localparam logic       c_HAS_CP   = (CP_LEN != 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CP   = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    logic [1:0]   r_state;
    logic [2:0]   r_idx;
    logic [W-1:0] r_buf_i [N_PT];
    logic [W-1:0] r_buf_q [N_PT];

    logic w_valid;
    logic w_accept;
    logic w_xfer;
    logic w_last_idx;

    // Handshake qualifiers; in_ready opens on the final DATA beat only when
    // that beat is actually leaving, which is what allows gapless symbols.
    always_comb begin
        w_valid    = (r_state == c_ST_CP) || (r_state == c_ST_DATA);
        w_last_idx = (r_idx == c_IDX_LAST);
        in_ready   = (r_state == c_ST_IDLE) ||
                     ((r_state == c_ST_DATA) && w_last_idx && out_ready);
        w_accept   = in_valid && in_ready;
        w_xfer     = w_valid && out_ready;
    end

    // Output beat: 8:1 mux from the registered buffers, zeroed when idle.
    always_comb begin
        out_valid = w_valid;
        out_i     = '0;
        out_q     = '0;
        out_is_cp = (r_state == c_ST_CP);
        out_eop   = (r_state == c_ST_DATA) && w_last_idx;
        out_sop   = ((r_state == c_ST_CP) && (r_idx == c_CP_START)) ||
                    ((r_state == c_ST_DATA) && (r_idx == 3'd0) && !c_HAS_CP);
        if (w_valid) begin
            out_i = r_buf_i[r_idx];
            out_q = r_buf_q[r_idx];
        end
    end

    // Frame capture: both buffers are overwritten on every accepted frame,
    // including the accept that coincides with the previous symbol's eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_PT; k++) begin
                r_buf_i[k] <= '0;
                r_buf_q[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < N_PT; k++) begin
                r_buf_i[k] <= in_phase[k*W +: W];
                r_buf_q[k] <= in_quad[k*W +: W];
            end
        end
    end

    // Sequencer: IDLE -> CP (tail samples) -> DATA (samples 0..7) -> IDLE,
    // or straight into the next symbol when a frame lands on the eop beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 3'd0;
        end else if (w_accept) begin
            r_state <= c_HAS_CP ? c_ST_CP : c_ST_DATA;
            r_idx   <= c_HAS_CP ? c_CP_START : 3'd0;
        end else if (w_xfer) begin
            case (r_state)
                c_ST_CP: begin
                    if (w_last_idx) begin
                        r_state <= c_ST_DATA;
                        r_idx   <= 3'd0;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_last_idx) begin
                        r_state <= c_ST_IDLE;
                        r_idx   <= 3'd0;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofdm_cp_serializer
//  Description : Directed vector bench for ofdm_cp_serializer, covering a
//                CP_LEN=2 instance and a CP_LEN=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofdm_cp_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_phase = '0;
    logic [127:0] in_quad  = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic         a_rdy, a_valid, a_sop, a_eop, a_cp;
    logic [15:0]  a_i, a_q;
    logic         z_rdy, z_valid, z_sop, z_eop, z_cp;
    logic [15:0]  z_i, z_q;

    always #5 clk = ~clk;

    ofdm_cp_serializer #(.N_PT(8), .W(16), .CP_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_phase(in_phase), .in_quad(in_quad),
        .in_valid(in_valid), .in_ready(a_rdy),
        .out_i(a_i), .out_q(a_q), .out_valid(a_valid), .out_ready(out_ready),
        .out_sop(a_sop), .out_eop(a_eop), .out_is_cp(a_cp)
    );

    ofdm_cp_serializer #(.N_PT(8), .W(16), .CP_LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_phase(in_phase), .in_quad(in_quad),
        .in_valid(in_valid), .in_ready(z_rdy),
        .out_i(z_i), .out_q(z_q), .out_valid(z_valid), .out_ready(out_ready),
        .out_sop(z_sop), .out_eop(z_eop), .out_is_cp(z_cp)
    );

    // One record per clock cycle: stimulus, then the expected outputs.
    typedef struct {
        logic        iv;
        logic [15:0] ib;
        logic [15:0] qb;
        logic        ordy;
        logic        cd;     // compare sample data on this cycle
        logic        ev;
        logic [15:0] ei;
        logic [15:0] eq;
        logic        esop;
        logic        eeop;
        logic        ecp;
        logic        erdy;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [127:0] mkframe(input logic [15:0] base);
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[16*k +: 16] = base + 16'(k);
        return f;
    endfunction

    task automatic cmp(input string name, input int n,
                       input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual v/i/q/sop/eop/cp/rdy=%h required=%h",
                     name, n, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [15:0] ib, input logic [15:0] qb,
                       input logic ordy, input logic cd, input logic ev,
                       input logic [15:0] ei, input logic [15:0] eq,
                       input logic esop, input logic eeop, input logic ecp,
                       input logic erdy);
        vec_t v;
        v.iv = iv; v.ib = ib; v.qb = qb; v.ordy = ordy; v.cd = cd; v.ev = ev;
        v.ei = ei; v.eq = eq; v.esop = esop; v.eeop = eeop; v.ecp = ecp;
        v.erdy = erdy;
        vq.push_back(v);
    endtask

    // Accept cycle straight after reset: idle, cleared buffers, ready.
    task automatic add_accept(input logic [15:0] ib, input logic [15:0] qb);
        add(1'b1, ib, qb, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic add_idle();
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // First nb beats of a symbol with out_ready=1; (niv,nib,nqb) is what
    // upstream presents meanwhile.
    task automatic add_sym(input logic [15:0] ib, input logic [15:0] qb,
                           input int cp, input int nb, input logic niv,
                           input logic [15:0] nib, input logic [15:0] nqb);
        for (int b = 0; b < nb; b++) begin
            int   s;
            logic last;
            s    = (b < cp) ? (8 - cp + b) : (b - cp);
            last = (b == 7 + cp);
            add(niv, nib, nqb, 1'b1, 1'b1, 1'b1, ib + 16'(s), qb + 16'(s),
                b == 0, last, b < cp, last);
        end
    endtask

    task automatic run_vecs(input string name, input bit use0);
        logic [36:0] act, exp, mask;
        for (int n = 0; n < vq.size(); n++) begin
            @(negedge clk);
            in_valid  = vq[n].iv;
            in_phase  = mkframe(vq[n].ib);
            in_quad   = mkframe(vq[n].qb);
            out_ready = vq[n].ordy;
            #1;
            act = use0 ? {z_valid, z_i, z_q, z_sop, z_eop, z_cp, z_rdy}
                       : {a_valid, a_i, a_q, a_sop, a_eop, a_cp, a_rdy};
            exp = {vq[n].ev, vq[n].ei, vq[n].eq, vq[n].esop, vq[n].eeop,
                   vq[n].ecp, vq[n].erdy};
            mask = vq[n].cd ? {37{1'b1}} : {1'b1, 32'h0, 4'hf};
            cmp(name, n, act & mask, exp & mask);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Single frame, CP_LEN=2
        do_reset();
        add_accept(16'h0010, 16'h0020);
        add_sym(16'h0010, 16'h0020, 2, 10, 1'b0, 16'h0, 16'h0);
        add_idle();
        run_vecs("single", 1'b0);

        // Back-to-back A then B; B held during A (ignored until eop)
        do_reset();
        add_accept(16'h0010, 16'h0020);
        add_sym(16'h0010, 16'h0020, 2, 10, 1'b1, 16'h0040, 16'h0050);
        add_sym(16'h0040, 16'h0050, 2, 10, 1'b0, 16'h0, 16'h0);
        add_idle();
        run_vecs("b2b", 1'b0);

        // Backpressure: out_ready pattern 1,0,0 repeating
        do_reset();
        add_accept(16'h0010, 16'h0020);
        begin
            int b, c;
            b = 0; c = 0;
            while (b < 10) begin
                int   s;
                logic ordy, last;
                ordy = (c % 3 == 0);
                s    = (b < 2) ? (6 + b) : (b - 2);
                last = (b == 9);
                add(1'b0, 16'h0, 16'h0, ordy, 1'b1, 1'b1, 16'h0010 + 16'(s),
                    16'h0020 + 16'(s), b == 0, last, b < 2, last && ordy);
                if (ordy) b++;
                c++;
            end
        end
        add_idle();
        run_vecs("bpress", 1'b0);

        // CP_LEN=0 instance
        do_reset();
        add_accept(16'h0010, 16'h0020);
        add_sym(16'h0010, 16'h0020, 0, 8, 1'b0, 16'h0, 16'h0);
        add_idle();
        run_vecs("nocp", 1'b1);

        // Reset pulse during data beat 3
        do_reset();
        add_accept(16'h0010, 16'h0020);
        add_sym(16'h0010, 16'h0020, 2, 5, 1'b0, 16'h0, 16'h0);
        run_vecs("rst_pre", 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        cmp("rst_d3", 0, {a_valid, a_i, a_q, a_sop, a_eop, a_cp, a_rdy},
            {1'b1, 16'h0013, 16'h0023, 4'b0000});
        rst_n = 1'b0;
        #1;
        cmp("rst_async", 0, {a_valid, a_i, a_q, a_sop, a_eop, a_cp, a_rdy},
            {1'b0, 32'h0, 4'b0001});
        @(negedge clk);
        #1;
        cmp("rst_hold", 0, {a_valid, a_i, a_q, a_sop, a_eop, a_cp, a_rdy},
            {1'b0, 32'h0, 4'b0001});
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        cmp("rst_idle", 0, {a_valid, a_i, a_q, a_sop, a_eop, a_cp, a_rdy},
            {1'b0, 32'h0, 4'b0001});
        add_accept(16'h0030, 16'h0040);
        add_sym(16'h0030, 16'h0040, 2, 10, 1'b0, 16'h0, 16'h0);
        add_idle();
        run_vecs("rst_post", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
